// File: rtl/imem_responder.sv
// Instruction-memory responder: fixed-latency fetch pipeline feeding an in-order
// response FIFO, with a side preload port into the word array.
module imem_responder #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2,
    parameter int QDEPTH      = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [ADDR_W-1:0]              req_addr,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [DATA_W-1:0]              rsp_data,
    output logic                           rsp_err,
    input  logic                           ld_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr,
    input  logic [DATA_W-1:0]              ld_data
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = $clog2(QDEPTH + 1);
    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

    logic [DATA_W-1:0] mem_r [DEPTH_WORDS];

    logic                 live_r;
    logic [CNT_W-1:0]     outst_r;
    logic [LATENCY-1:0]   pipe_vld_r;
    logic [LATENCY-1:0]   pipe_err_r;
    logic [DATA_W-1:0]    pipe_data_r [LATENCY];
    logic [DATA_W-1:0]    fifo_data_r [QDEPTH];
    logic [QDEPTH-1:0]    fifo_err_r;
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [CNT_W-1:0]     fcnt_r;

    logic                 accept_s;
    logic                 pop_s;
    logic                 push_s;
    logic                 err_s;
    logic [IDX_W-1:0]     word_s;
    logic [DATA_W-1:0]    rdata_s;

    // Misaligned addresses and indices beyond the array are errors; upper bits never alias.
    function automatic logic fetch_err(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-3:0] idx;
        idx = a[ADDR_W-1:2];
        return (a[1:0] != 2'b00) || (idx >= (ADDR_W-2)'(DEPTH_WORDS));
    endfunction

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(QDEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    // req_ready only looks at registered state so it can never loop through the consumer.
    assign req_ready = live_r && (outst_r < CNT_W'(QDEPTH));
    assign accept_s  = req_valid && req_ready;
    assign rsp_valid = (fcnt_r != {CNT_W{1'b0}});
    assign pop_s     = rsp_valid && rsp_ready;
    assign push_s    = pipe_vld_r[LATENCY-1];
    assign rsp_data  = rsp_valid ? fifo_data_r[rd_ptr_r] : {DATA_W{1'b0}};
    assign rsp_err   = rsp_valid ? fifo_err_r[rd_ptr_r] : 1'b0;

    // Address decode and array read for the request presented this cycle.
    always_comb begin
        err_s   = fetch_err(req_addr);
        word_s  = req_addr[IDX_W+1:2];
        rdata_s = {DATA_W{1'b0}};
        if (err_s) begin
            rdata_s = {DATA_W{1'b0}};
        end else begin
            rdata_s = mem_r[word_s];
        end
    end

    // Preload write port; the array deliberately keeps its contents through reset.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem_r[ld_addr] <= ld_data;
        end
    end

    // Acceptance is held off until the first edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            live_r <= 1'b0;
        end else begin
            live_r <= 1'b1;
        end
    end

    // Outstanding count covers both in-flight and queued responses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            outst_r <= {CNT_W{1'b0}};
        end else begin
            case ({accept_s, pop_s})
                2'b10:   outst_r <= outst_r + CNT_W'(1);
                2'b01:   outst_r <= outst_r - CNT_W'(1);
                default: outst_r <= outst_r;
            endcase
        end
    end

    // Valid-tagged read pipeline; never stalls because the FIFO is sized for all outstanding work.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe_vld_r <= {LATENCY{1'b0}};
            pipe_err_r <= {LATENCY{1'b0}};
            for (int i = 0; i < LATENCY; i++) begin
                pipe_data_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            pipe_vld_r[0]  <= accept_s;
            pipe_err_r[0]  <= err_s;
            pipe_data_r[0] <= rdata_s;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_vld_r[i]  <= pipe_vld_r[i-1];
                pipe_err_r[i]  <= pipe_err_r[i-1];
                pipe_data_r[i] <= pipe_data_r[i-1];
            end
        end
    end

    // In-order response FIFO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            fcnt_r     <= {CNT_W{1'b0}};
            fifo_err_r <= {QDEPTH{1'b0}};
            for (int i = 0; i < QDEPTH; i++) begin
                fifo_data_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            if (push_s) begin
                fifo_data_r[wr_ptr_r] <= pipe_data_r[LATENCY-1];
                fifo_err_r[wr_ptr_r]  <= pipe_err_r[LATENCY-1];
                wr_ptr_r              <= next_ptr(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   fcnt_r <= fcnt_r + CNT_W'(1);
                2'b01:   fcnt_r <= fcnt_r - CNT_W'(1);
                default: fcnt_r <= fcnt_r;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: directed test-plan steps then random traffic, checked
// against a queue-based model of accepted fetches with their earliest response edge.
module tb_imem_responder;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int DEP = 256;
    localparam int LAT = 2;
    localparam int QD  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic          ld_en;
    logic [7:0]    ld_addr;
    logic [DW-1:0] ld_data;

    always #5 clk = ~clk;

    imem_responder #(
        .ADDR_W(AW), .DATA_W(DW), .DEPTH_WORDS(DEP), .LATENCY(LAT), .QDEPTH(QD)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          rdy;
    } ent_t;

    ent_t        q[$];
    logic [31:0] mmem [DEP];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    bit          live = 1'b0;
    int          obs_acc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic er;
        logic ev;
        er = live && (q.size() < QD);
        ev = (q.size() > 0) && (q[0].rdy <= cyc);
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("rsp_valid", 32'(rsp_valid), 32'(ev));
        if (ev && rsp_valid) begin
            chk("rsp_data", rsp_data, q[0].data);
            chk("rsp_err", 32'(rsp_err), 32'(q[0].err));
        end
    endtask

    // One cycle: drive at the falling edge, check, advance the model over the rising edge.
    task automatic step(input logic v, input logic [31:0] a, input logic rr,
                        input logic le = 1'b0, input logic [7:0] la = 8'd0,
                        input logic [31:0] ld = 32'd0);
        logic acc;
        logic pop;
        ent_t e;
        ent_t dummy;
        req_valid = v; req_addr = a; rsp_ready = rr;
        ld_en = le; ld_addr = la; ld_data = ld;
        check_outputs();
        if (v && req_ready) obs_acc++;
        acc = v && live && (q.size() < QD);
        pop = rr && (q.size() > 0) && (q[0].rdy <= cyc);
        e.err  = (a % 4 != 0) || ((a / 4) >= DEP);
        e.data = e.err ? 32'd0 : mmem[a / 4];
        @(posedge clk);
        cyc++;
        if (pop) dummy = q.pop_front();
        if (acc) begin
            e.rdy = cyc + LAT;
            q.push_back(e);
        end
        if (le) mmem[la] = ld;
        if (reset) live = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b1);
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 7)       return 32'($urandom_range(0, DEP - 1) * 4);
        else if (r == 7) return 32'($urandom_range(0, DEP - 1) * 4 + $urandom_range(1, 3));
        else if (r == 8) return 32'($urandom_range(DEP, 1023) * 4);
        else             return $urandom;
    endfunction

    logic [31:0] boot [4];

    initial begin
        boot[0] = 32'h00000013; boot[1] = 32'h00100093;
        boot[2] = 32'h00200113; boot[3] = 32'h00308193;
        reset = 1'b1; req_valid = 1'b0; req_addr = 32'd0; rsp_ready = 1'b0;
        ld_en = 1'b0; ld_addr = 8'd0; ld_data = 32'd0;
        #2 reset = 1'b0;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Preload the whole array; the boot program occupies words 0..3.
        for (int i = 0; i < DEP; i++)
            step(1'b0, 32'd0, 1'b1, 1'b1, 8'(i), (i < 4) ? boot[i] : $urandom);

        // Back-to-back fetches.
        for (int i = 0; i < 4; i++) step(1'b1, 32'(i * 4), 1'b1);
        idle(6);

        // Backpressure: only QD requests fit.
        obs_acc = 0;
        for (int i = 0; i < 6; i++) step(1'b1, 32'($urandom_range(0, DEP - 1) * 4), 1'b0);
        chk("bp_accepts", 32'(obs_acc), 32'd4);
        for (int i = 0; i < 6; i++) step(1'b0, 32'd0, 1'b1);

        // Error decode and last word.
        step(1'b1, 32'h2, 1'b1);
        step(1'b1, 32'h400, 1'b1);
        step(1'b1, 32'h3FC, 1'b1);
        idle(5);

        // Full queue then simultaneous request and pop traffic.
        for (int i = 0; i < 4; i++) step(1'b1, 32'($urandom_range(0, DEP - 1) * 4), 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 32'($urandom_range(0, DEP - 1) * 4), 1'b1);
        idle(6);

        // Reset between edges with three fetches outstanding.
        for (int i = 0; i < 3; i++) step(1'b1, 32'($urandom_range(0, DEP - 1) * 4), 1'b0);
        #2 reset = 1'b0;
        #1;
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd0);
        chk("midrst_rsp_data", rsp_data, 32'd0);
        q.delete();
        live = 1'b0;
        @(negedge clk);
        step(1'b1, 32'h4, 1'b1);
        step(1'b0, 32'd0, 1'b1);
        reset = 1'b1;
        idle(4);
        step(1'b1, 32'h4, 1'b1);
        idle(5);

        // Preload write colliding with a fetch of the same word.
        step(1'b1, 32'h4, 1'b1, 1'b1, 8'd1, 32'hDEADBEEF);
        step(1'b1, 32'h4, 1'b1);
        idle(5);

        // Random traffic.
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), rand_addr(), ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 9) == 0), 8'($urandom_range(0, DEP - 1)), $urandom);

        for (int i = 0; i < 20; i++) begin
            if (q.size() > 0) step(1'b0, 32'd0, 1'b1);
        end
        chk("drain_empty", 32'(q.size()), 32'd0);
        chk("drain_rsp_valid", 32'(rsp_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
